// File: rtl/burst_mem_responder_if.sv
// Burst pmem bus between a cacheline requester (master) and the memory
// responder (slave). The requester holds mem_read/mem_write until the last
// beat; the responder pulses mem_resp once per beat.
interface burst_mem_responder_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) ();
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Physical-memory responder for the 64-bit burst pmem interface.
// Serves line-aligned reads/writes as BEATS-long bursts after LATENCY idle
// cycles, backed by an on-chip line array that is never cleared by reset.
// Optional feature: define BURST_MEM_PROTO_CHECK_EN to build the sticky
// protocol checker behind proto_err; otherwise proto_err is tied low.
module burst_mem_responder #(
    parameter int DATA_W      = 64,
    parameter int BEATS       = 4,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    burst_mem_responder_if.slave   bus,
    output logic                   proto_err
);
    localparam int OFS = $clog2(DATA_W * BEATS / 8);
    localparam int IDX = $clog2(DEPTH_LINES);
    localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [IDX-1:0]  idx_q, idx_d;
    logic            op_wr_q, op_wr_d;
    logic [DATA_W-1:0] rdata_q;
    logic            req;
    logic            beat_ok;
    logic [IDX-1:0]  addr_idx;

    // Line storage, one word per beat; intentionally not reset.
    logic [DATA_W-1:0] mem_q [DEPTH_LINES][BEATS];

    assign req      = bus.mem_read | bus.mem_write;
    assign addr_idx = bus.mem_address[OFS+IDX-1:OFS];

    // A beat is only presented while the requester still holds its request,
    // so a dropped request never sees another resp pulse.
    assign beat_ok       = (state_q == BURST) && req;
    assign bus.mem_resp  = beat_ok;
    assign bus.mem_rdata = rdata_q;

    // Next-state, latched-op and counter logic.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        op_wr_d = op_wr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = addr_idx;
                    op_wr_d = bus.mem_write;  // write wins when both are set
                    lat_d   = LW'(LATENCY);
                    beat_d  = '0;
                    state_d = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    lat_d   = '0;
                end else if (lat_q <= LW'(1)) begin
                    state_d = BURST;
                    lat_d   = '0;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            BURST: begin
                if (!req) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (beat_q == BW'(BEATS - 1)) begin
                    state_d = DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            op_wr_q <= op_wr_d;
        end
    end

    // Read beat is fetched at the edge entering each read resp cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if ((state_d == BURST) && !op_wr_d) begin
            rdata_q <= mem_q[idx_d][beat_d];
        end
    end

    // Write beat is captured at the edge closing each write resp cycle.
    always_ff @(posedge clk) begin
        if (beat_ok && op_wr_q) begin
            mem_q[idx_q][beat_q] <= bus.mem_wdata;
        end
    end

`ifdef BURST_MEM_PROTO_CHECK_EN
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              in_burst;
    logic              viol;

    assign in_burst = (state_q == WAIT) || (state_q == BURST);

    // Any protocol violation seen in the current cycle.
    always_comb begin
        viol = 1'b0;
        if (bus.mem_read && bus.mem_write) viol = 1'b1;
        if (in_burst && !req) viol = 1'b1;
        if (in_burst && req &&
            ((bus.mem_address != addr_q) || (bus.mem_write != op_wr_q))) viol = 1'b1;
        if ((state_q == IDLE) && req && (|bus.mem_address[OFS-1:0])) viol = 1'b1;
    end

    // Full request address for change detection, and the sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req) addr_q <= bus.mem_address;
            err_q <= err_q | viol;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

    // Offset and upper address bits are deliberately ignored by the datapath.
    logic unused_addr;
    assign unused_addr = ^bus.mem_address;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: one LATENCY=8 instance and one
// LATENCY=0 instance on a shared clock and reset.
module tb_burst_mem_responder;
    localparam int BEATS = 4;

`ifdef BURST_MEM_PROTO_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    burst_mem_responder_if #(.DATA_W(64), .ADDR_W(32)) bus0 ();
    burst_mem_responder_if #(.DATA_W(64), .ADDR_W(32)) bus8 ();
    logic perr0, perr8;

    burst_mem_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .proto_err(perr0));
    burst_mem_responder #(.LATENCY(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8), .proto_err(perr8));

    // Index 0 drives the LATENCY=0 instance, index 1 the LATENCY=8 instance.
    logic        rd_v [2];
    logic        wr_v [2];
    logic [31:0] ad_v [2];
    logic [63:0] wd_v [2];
    logic        resp_w [2];
    logic [63:0] rdata_w [2];

    assign bus0.mem_read    = rd_v[0];
    assign bus0.mem_write   = wr_v[0];
    assign bus0.mem_address = ad_v[0];
    assign bus0.mem_wdata   = wd_v[0];
    assign bus8.mem_read    = rd_v[1];
    assign bus8.mem_write   = wr_v[1];
    assign bus8.mem_address = ad_v[1];
    assign bus8.mem_wdata   = wd_v[1];
    assign resp_w[0]  = bus0.mem_resp;
    assign resp_w[1]  = bus8.mem_resp;
    assign rdata_w[0] = bus0.mem_rdata;
    assign rdata_w[1] = bus8.mem_rdata;

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] wb [BEATS];  // beats to write
    logic [63:0] xb [BEATS];  // beats expected on read

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // One complete burst; checks resp in every cycle from acceptance through
    // the DONE gap and read data on each beat. b2b skips the re-arm edge when
    // the previous call left its request held; hold keeps the request up.
    task automatic burst(input int sel, input bit wr, input logic [31:0] addr,
                         input bit b2b, input bit hold, input string tag);
        int lat  = (sel == 0) ? 0 : 8;
        int beat = 0;
        int n    = lat + BEATS + 1;
        logic exp_r;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        rd_v[sel] = !wr;
        wr_v[sel] = wr;
        ad_v[sel] = addr;
        wd_v[sel] = wb[0];
        @(posedge clk); #1;  // acceptance edge
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            exp_r = (k >= lat + 1) && (k <= lat + BEATS);
            chk($sformatf("%s_resp%0d", tag, k), {63'd0, resp_w[sel]}, {63'd0, exp_r});
            if (resp_w[sel] && (beat < BEATS)) begin
                if (!wr) chk($sformatf("%s_data%0d", tag, beat), rdata_w[sel], xb[beat]);
                beat++;
            end
            @(posedge clk); #1;
            if (beat < BEATS) wd_v[sel] = wb[beat];
        end
        if (!hold) begin
            rd_v[sel] = 1'b0;
            wr_v[sel] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd_v[i] = 1'b0; wr_v[i] = 1'b0; ad_v[i] = '0; wd_v[i] = '0;
        end
        // Reset state
        #12;
        chk("rst_resp8", {63'd0, resp_w[1]}, 64'd0);
        chk("rst_rdata8", rdata_w[1], 64'd0);
        chk("rst_perr8", {63'd0, perr8}, 64'd0);
        chk("rst_resp0", {63'd0, resp_w[0]}, 64'd0);
        chk("rst_perr0", {63'd0, perr0}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: reset asserted mid-WAIT, no beat afterwards
        @(posedge clk); #1;
        rd_v[1] = 1'b1; ad_v[1] = 32'h0000_0040;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        rd_v[1] = 1'b0;
        #2;
        chk("t1_resp_in_rst", {63'd0, resp_w[1]}, 64'd0);
        chk("t1_perr_in_rst", {63'd0, perr8}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("t1_quiet%0d", k), {63'd0, resp_w[1]}, 64'd0);
        end

        // 2: write then read line 0x40 with LATENCY=8
        wb[0] = 64'h1111_1111_1111_1111; wb[1] = 64'h2222_2222_2222_2222;
        wb[2] = 64'h3333_3333_3333_3333; wb[3] = 64'h4444_4444_4444_4444;
        burst(1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, "t2_wr");
        xb = wb;
        burst(1, 1'b0, 32'h0000_0040, 1'b0, 1'b0, "t2_rd");

        // 3: LATENCY=0 write then read, resp in cycles 1..4 and gap in 5
        wb[0] = 64'hDEAD_BEEF_0000_0001; wb[1] = 64'hDEAD_BEEF_0000_0002;
        wb[2] = 64'hDEAD_BEEF_0000_0003; wb[3] = 64'hDEAD_BEEF_0000_0004;
        burst(0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, "t3_wr");
        xb = wb;
        burst(0, 1'b0, 32'h0000_0040, 1'b0, 1'b0, "t3_rd");

        // 4: 0x2040 and 0x0040 both map to index 2
        wb[0] = 64'hA1A1_A1A1_0000_0000; wb[1] = 64'hA2A2_A2A2_0000_0000;
        wb[2] = 64'hA3A3_A3A3_0000_0000; wb[3] = 64'hA4A4_A4A4_0000_0000;
        burst(1, 1'b1, 32'h0000_2040, 1'b0, 1'b0, "t4_wr");
        xb = wb;
        burst(1, 1'b0, 32'h0000_0040, 1'b0, 1'b0, "t4_rd");

        // 6: read held through DONE is accepted only on the following edge
        burst(1, 1'b0, 32'h0000_0040, 1'b0, 1'b1, "t6_a");
        burst(1, 1'b0, 32'h0000_0040, 1'b1, 1'b0, "t6_b");
        @(negedge clk);
        chk("clean_perr8", {63'd0, perr8}, 64'd0);

        // 5: drop read after beat 1
        @(posedge clk); #1;
        rd_v[1] = 1'b1; ad_v[1] = 32'h0000_0040;
        @(posedge clk); #1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("t5_resp%0d", k), {63'd0, resp_w[1]}, {63'd0, (k >= 9)});
            if (k == 10) chk("t5_beat1", rdata_w[1], xb[1]);
            @(posedge clk); #1;
        end
        rd_v[1] = 1'b0;
        for (int k = 11; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("t5_noresp%0d", k), {63'd0, resp_w[1]}, 64'd0);
            if (k == 12 || k == 16) chk($sformatf("t5_perr%0d", k), {63'd0, perr8}, {63'd0, PCHK});
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        chk("t5_perr_cleared", {63'd0, perr8}, 64'd0);
        chk("t5_rdata_cleared", rdata_w[1], 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // storage survives reset
        burst(1, 1'b0, 32'h0000_0040, 1'b0, 1'b0, "keep_rd");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
